// File: rtl/jtag_tap_controller.sv
// -----------------------------------------------------------------------------
// jtag_tap_controller
//   IEEE 1149.1 TAP state machine. Walks the 16-state TAP graph from TMS,
//   publishes the current state and generates the instruction/data register
//   capture, shift and update controls, the IR reset and the TDO mux.
//   It also counts Shift-IR clocks and raises a sticky flag when an IR scan
//   does not contain exactly IR_LEN shift clocks.
//
// Ports
//   tck        in   TAP clock; state on rising edge, TDO path on falling edge
//   reset      in   asynchronous reset, active low
//   tms        in   test mode select
//   ir_tdo     in   serial output of the instruction register
//   dr_tdo     in   serial output of the selected data register
//   state      out  current TAP state (4-bit standard encoding)
//   clkIR      out  IR clock enable (Capture-IR, Shift-IR)
//   shIR       out  IR shift (1) / parallel capture (0)
//   upIR       out  IR update strobe, active low (Update-IR)
//   clkDR      out  DR clock enable (Capture-DR, Shift-DR)
//   shDR       out  DR shift
//   upDR       out  DR update strobe, active low (Update-DR)
//   ir_reset   out  IR reset, active low (Test-Logic-Reset)
//   tdo        out  registered test data out
//   tdo_en     out  TDO drive enable
//   ir_len_err out  sticky malformed-IR-scan flag
// -----------------------------------------------------------------------------
module jtag_tap_controller #(
   parameter int IR_LEN = 3,
   parameter int CNT_W  = 8
) (
   input  logic       tck,
   input  logic       reset,
   input  logic       tms,
   input  logic       ir_tdo,
   input  logic       dr_tdo,
   output logic [3:0] state,
   output logic       clkIR,
   output logic       shIR,
   output logic       upIR,
   output logic       clkDR,
   output logic       shDR,
   output logic       upDR,
   output logic       ir_reset,
   output logic       tdo,
   output logic       tdo_en,
   output logic       ir_len_err
);

   typedef enum logic [3:0] {
      TLR     = 4'hF,
      RTI     = 4'hC,
      SELDR   = 4'h7,
      CAPDR   = 4'h6,
      SHDR    = 4'h2,
      EX1DR   = 4'h1,
      PAUSEDR = 4'h3,
      EX2DR   = 4'h0,
      UPDR    = 4'h5,
      SELIR   = 4'h4,
      CAPIR   = 4'hE,
      SHIR    = 4'hA,
      EX1IR   = 4'h9,
      PAUSEIR = 4'hB,
      EX2IR   = 4'h8,
      UPIR    = 4'hD
   } tap_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] IR_LEN_C = CNT_W'(IR_LEN);

   tap_state_e       state_q, state_d;
   logic             clkIR_q, shIR_q, upIR_q;
   logic             clkDR_q, shDR_q, upDR_q;
   logic             ir_reset_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             tdo_q, tdo_en_q;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:     state_d = tms ? TLR     : RTI;
         RTI:     state_d = tms ? SELDR   : RTI;
         SELDR:   state_d = tms ? SELIR   : CAPDR;
         CAPDR:   state_d = tms ? EX1DR   : SHDR;
         SHDR:    state_d = tms ? EX1DR   : SHDR;
         EX1DR:   state_d = tms ? UPDR    : PAUSEDR;
         PAUSEDR: state_d = tms ? EX2DR   : PAUSEDR;
         EX2DR:   state_d = tms ? UPDR    : SHDR;
         UPDR:    state_d = tms ? SELDR   : RTI;
         SELIR:   state_d = tms ? TLR     : CAPIR;
         CAPIR:   state_d = tms ? EX1IR   : SHIR;
         SHIR:    state_d = tms ? EX1IR   : SHIR;
         EX1IR:   state_d = tms ? UPIR    : PAUSEIR;
         PAUSEIR: state_d = tms ? EX2IR   : PAUSEIR;
         EX2IR:   state_d = tms ? UPIR    : SHIR;
         UPIR:    state_d = tms ? SELDR   : RTI;
         default: state_d = TLR;
      endcase
   end

   // IR bit counter and scan-length check. The error is evaluated on the
   // edge leaving Update-IR, so cnt_q still holds the completed scan count.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == CAPIR) begin
         cnt_d = '0;
      end else if ((state_q == SHIR) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      err_d = err_q;
      if (state_d == TLR) begin
         err_d = 1'b0;
      end else if ((state_q == UPIR) && (cnt_q != IR_LEN_C)) begin
         err_d = 1'b1;
      end
   end

   // Rising-edge stage: state plus controls decoded from next state, so each
   // control is a flop output aligned with the state it belongs to.
   always_ff @(posedge tck or negedge reset) begin
      if (!reset) begin
         state_q    <= TLR;
         clkIR_q    <= 1'b0;
         shIR_q     <= 1'b0;
         upIR_q     <= 1'b1;
         clkDR_q    <= 1'b0;
         shDR_q     <= 1'b0;
         upDR_q     <= 1'b1;
         ir_reset_q <= 1'b0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clkIR_q    <= (state_d == CAPIR) || (state_d == SHIR);
         shIR_q     <= (state_d == SHIR);
         upIR_q     <= (state_d != UPIR);
         clkDR_q    <= (state_d == CAPDR) || (state_d == SHDR);
         shDR_q     <= (state_d == SHDR);
         upDR_q     <= (state_d != UPDR);
         ir_reset_q <= (state_d != TLR);
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   // Falling-edge stage: TDO is launched half a cycle after the shift edge.
   always_ff @(negedge tck or negedge reset) begin
      if (!reset) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else if (state_q == SHIR) begin
         tdo_q    <= ir_tdo;
         tdo_en_q <= 1'b1;
      end else if (state_q == SHDR) begin
         tdo_q    <= dr_tdo;
         tdo_en_q <= 1'b1;
      end else begin
         tdo_en_q <= 1'b0;
      end
   end

   assign state      = state_q;
   assign clkIR      = clkIR_q;
   assign shIR       = shIR_q;
   assign upIR       = upIR_q;
   assign clkDR      = clkDR_q;
   assign shDR       = shDR_q;
   assign upDR       = upDR_q;
   assign ir_reset   = ir_reset_q;
   assign tdo        = tdo_q;
   assign tdo_en     = tdo_en_q;
   assign ir_len_err = err_q;

endmodule
